pq_stream_sorter: RTL and testbench

- Host-side driver for the priority-queue device interface; it is the initiator of the push/pop handshake.
- Loads one frame of key-value pairs from an upstream valid/ready stream into the PQ, then drains it downstream in ascending key order.
- Sits between a packet source and any PQ instance (shift-register or other) sharing the pq_pkg types.
- Output frame is marked with out_last; completion is signalled with done.

---
 rtl/pq_pkg.sv | 27 ++
 rtl/pq_sorter_ctl.sv | 145 ++++++++++++++
 rtl/pq_stream_sorter.sv | 103 ++++++++++
 tb/tb_pq_stream_sorter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared priority-queue types: key/value pair, the KEYINF sentinel and the
// sorter state encoding, plus the sentinel test used by the stream sorter.
package pq_pkg;

   localparam int KEY_W       = 16;
   localparam int VAL_W       = 16;
   localparam int PQ_CAPACITY = 16;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] val;
   } kv_t;

   // All-ones key marks an empty PQ slot, so it can never be stored as data.
   localparam logic [KEY_W-1:0] KEYINF = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } sorter_state_t;

   function automatic logic is_inf(input kv_t kv);
      return (kv.key == KEYINF);
   endfunction

endpackage

// File: rtl/pq_sorter_ctl.sv
// Load/drain sequencer for the PQ stream sorter: owns the state machine, the
// frame occupancy count, overflow discard tracking and the sticky errors.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no frame in progress; first accepted pair starts a frame
//   LOAD  | accepting pairs and pushing them into the PQ
//   DRAIN | popping PQ head downstream until count reaches zero
module pq_sorter_ctl
   import pq_pkg::*;
#(
   parameter int MAX_FRAME = PQ_CAPACITY,
   parameter int CNT_W     = $clog2(MAX_FRAME + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_last,
   input  logic             in_is_inf,
   input  logic             pq_irdy,
   input  logic             pq_full,
   input  logic             pq_busy,
   input  logic             pq_ovalid,
   input  logic             out_ready,
   output logic             in_ready,
   output logic             pq_ivalid,
   output logic             pq_ordy,
   output logic             out_valid,
   output logic             out_last,
   output logic [CNT_W-1:0] count,
   output logic             done,
   output logic             err_drop,
   output logic             err_ovf
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_FRAME);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   sorter_state_t    r_state;
   sorter_state_t    w_state_nxt;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic [CNT_W-1:0] w_cnt_load;
   logic             r_discard;
   logic             w_discard_nxt;
   logic             r_err_drop;
   logic             r_err_ovf;
   logic             w_drop_set;
   logic             w_ovf_set;
   logic             w_done;
   logic             w_acc_ok;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_load_acc;
   logic             w_push;
   logic             w_out_valid;
   logic             w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_discard  <= 1'b0;
         r_err_drop <= 1'b0;
         r_err_ovf  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         r_discard  <= w_discard_nxt;
         r_err_drop <= r_err_drop | w_drop_set;
         r_err_ovf  <= r_err_ovf | w_ovf_set;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_count_nxt   = r_count;
      w_discard_nxt = r_discard;
      w_drop_set    = 1'b0;
      w_ovf_set     = 1'b0;
      w_done        = 1'b0;
      w_in_ready    = 1'b0;

      w_acc_ok = !pq_busy && pq_irdy && !pq_full && (r_count < MAX_C);

      // Overflow tail is swallowed in any state so a short drain cannot strand it.
      if (!rst) begin
         if (r_discard)
            w_in_ready = 1'b1;
         else if (r_state != DRAIN)
            w_in_ready = w_acc_ok;
      end

      w_accept    = in_valid && w_in_ready;
      w_load_acc  = w_accept && !r_discard && (r_state != DRAIN);
      w_push      = w_load_acc && !in_is_inf;
      w_cnt_load  = r_count + CNT_W'(w_push);
      w_out_valid = !rst && (r_state == DRAIN) && pq_ovalid && !pq_busy;
      w_pop       = w_out_valid && out_ready;

      if (r_discard && w_accept && in_last)
         w_discard_nxt = 1'b0;

      case (r_state)
         IDLE, LOAD: begin
            if (w_load_acc) begin
               w_count_nxt = w_cnt_load;
               w_drop_set  = in_is_inf;
               w_state_nxt = LOAD;
               if (in_last && (w_cnt_load == '0)) begin
                  w_done      = 1'b1;
                  w_state_nxt = IDLE;
               end else if (in_last || (w_cnt_load == MAX_C)) begin
                  w_state_nxt = DRAIN;
                  if (!in_last) begin
                     w_ovf_set     = 1'b1;
                     w_discard_nxt = 1'b1;
                  end
               end
            end
         end
         DRAIN: begin
            if (w_pop) begin
               w_count_nxt = r_count - ONE_C;
               if (r_count == ONE_C) begin
                  w_done      = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign in_ready  = w_in_ready;
   assign pq_ivalid = w_push;
   assign pq_ordy   = w_pop;
   assign out_valid = w_out_valid;
   assign out_last  = w_out_valid && (r_count == ONE_C);
   assign count     = r_count;
   assign done      = w_done;
   assign err_drop  = r_err_drop;
   assign err_ovf   = r_err_ovf;

endmodule

// File: rtl/pq_stream_sorter.sv
// Host-side PQ driver: loads one frame from the input stream into the PQ and
// drains it in ascending key order. Optional statistics via PQ_SORTER_STATS_EN.
module pq_stream_sorter
   import pq_pkg::*;
#(
   parameter int MAX_FRAME = PQ_CAPACITY,
   parameter int CNT_W     = $clog2(MAX_FRAME + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  kv_t              in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output kv_t              out_data,
   output logic             out_last,
   output logic             pq_ivalid,
   input  logic             pq_irdy,
   output kv_t              pq_idata,
   input  logic             pq_ovalid,
   output logic             pq_ordy,
   input  kv_t              pq_odata,
   input  logic             pq_full,
   input  logic             pq_busy,
   output logic [CNT_W-1:0] count,
   output logic             done,
   output logic             err_drop,
   output logic             err_ovf
`ifdef PQ_SORTER_STATS_EN
   ,
   output logic [15:0]      frames_done,
   output logic [31:0]      pairs_sorted,
   output logic [CNT_W-1:0] max_occ
`endif
);

   logic             w_in_is_inf;
   logic             w_pq_ordy;
   logic             w_done;
   logic [CNT_W-1:0] w_count;

   assign w_in_is_inf = is_inf(in_data);

   pq_sorter_ctl #(
      .MAX_FRAME (MAX_FRAME),
      .CNT_W     (CNT_W)
   ) u_ctl (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_is_inf (w_in_is_inf),
      .pq_irdy   (pq_irdy),
      .pq_full   (pq_full),
      .pq_busy   (pq_busy),
      .pq_ovalid (pq_ovalid),
      .out_ready (out_ready),
      .in_ready  (in_ready),
      .pq_ivalid (pq_ivalid),
      .pq_ordy   (w_pq_ordy),
      .out_valid (out_valid),
      .out_last  (out_last),
      .count     (w_count),
      .done      (w_done),
      .err_drop  (err_drop),
      .err_ovf   (err_ovf)
   );

   // Push and pop are pure pass-through; the PQ holds all frame data.
   assign pq_idata = in_data;
   assign out_data = pq_odata;
   assign pq_ordy  = w_pq_ordy;
   assign done     = w_done;
   assign count    = w_count;

`ifdef PQ_SORTER_STATS_EN
   logic [15:0]      r_frames_done;
   logic [31:0]      r_pairs_sorted;
   logic [CNT_W-1:0] r_max_occ;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frames_done  <= '0;
         r_pairs_sorted <= '0;
         r_max_occ      <= '0;
      end else begin
         if (w_done && (r_frames_done != '1))
            r_frames_done <= r_frames_done + 16'd1;
         if (w_pq_ordy && (r_pairs_sorted != '1))
            r_pairs_sorted <= r_pairs_sorted + 32'd1;
         if (w_count > r_max_occ)
            r_max_occ <= w_count;
      end
   end

   assign frames_done  = r_frames_done;
   assign pairs_sorted = r_pairs_sorted;
   assign max_occ      = r_max_occ;
`endif

endmodule

// File: tb/tb_pq_stream_sorter.sv
// Directed bench for pq_stream_sorter with a behavioural single-cycle PQ.
module tb_pq_stream_sorter;
   import pq_pkg::*;

   localparam int MAX_FRAME = 4;
   localparam int CNT_W     = $clog2(MAX_FRAME + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   kv_t              in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   kv_t              out_data;
   logic             out_last;
   logic             pq_ivalid;
   logic             pq_irdy;
   kv_t              pq_idata;
   logic             pq_ovalid;
   logic             pq_ordy;
   kv_t              pq_odata;
   logic             pq_full;
   logic             pq_busy;
   logic [CNT_W-1:0] count;
   logic             done;
   logic             err_drop;
   logic             err_ovf;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pq_stream_sorter #(.MAX_FRAME(MAX_FRAME), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .pq_ivalid(pq_ivalid), .pq_irdy(pq_irdy), .pq_idata(pq_idata),
      .pq_ovalid(pq_ovalid), .pq_ordy(pq_ordy), .pq_odata(pq_odata),
      .pq_full(pq_full), .pq_busy(pq_busy),
      .count(count), .done(done), .err_drop(err_drop), .err_ovf(err_ovf)
   );

   // Behavioural PQ: unordered slots, head is the smallest valid key.
   logic [PQ_CAPACITY-1:0] m_vld;
   kv_t                    m_mem [PQ_CAPACITY];
   int                     m_min;
   int                     m_free;
   logic                   m_min_ok;
   logic                   m_free_ok;

   always_comb begin
      m_min = 0; m_free = 0; m_min_ok = 1'b0; m_free_ok = 1'b0;
      for (int i = 0; i < PQ_CAPACITY; i++) begin
         if (m_vld[i] && (!m_min_ok || (m_mem[i].key < m_mem[m_min].key))) begin
            m_min = i; m_min_ok = 1'b1;
         end
         if (!m_vld[i] && !m_free_ok) begin
            m_free = i; m_free_ok = 1'b1;
         end
      end
   end

   assign pq_ovalid = m_min_ok;
   assign pq_odata  = m_mem[m_min];
   assign pq_full   = !m_free_ok;
   assign pq_irdy   = 1'b1;
   assign pq_busy   = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_vld <= '0;
      end else begin
         if (pq_ordy && pq_ovalid) m_vld[m_min] <= 1'b0;
         if (pq_ivalid && m_free_ok) begin
            m_vld[m_free]  <= 1'b1;
            m_mem[m_free]  <= pq_idata;
         end
      end
   end

   // Frame driver state and observations.
   kv_t         in_q[$];
   int          rdy_pat[$];
   logic [15:0] got[$];
   int n_acc, n_done, n_last, last_pos, done_pos, peak, n_ov, n_stall, stall_bad;
   int last_acc_cyc, first_ov_cyc;
   bit timeout;

   function automatic kv_t mk(input logic [15:0] k);
      kv_t r;
      r.key = k;
      r.val = k ^ 16'h5a5a;
      return r;
   endfunction

   task automatic drive_frame();
      int   idx = 0;
      int   cyc = 0;
      bit   held = 0;
      kv_t  held_d = '0;
      got.delete();
      n_acc = 0; n_done = 0; n_last = 0; last_pos = -1; done_pos = -2; peak = 0;
      n_ov = 0; n_stall = 0; stall_bad = 0; last_acc_cyc = -1; first_ov_cyc = -1;
      timeout = 1;
      while (cyc < 200) begin
         in_valid  = (idx < in_q.size());
         in_data   = (idx < in_q.size()) ? in_q[idx] : '0;
         in_last   = (idx == in_q.size() - 1);
         out_ready = (rdy_pat.size() == 0) ? 1'b1 : (rdy_pat[cyc % rdy_pat.size()] != 0);
         @(negedge clk);
         if (int'(count) > peak) peak = int'(count);
         if (in_valid && in_ready) begin
            idx++; n_acc++; last_acc_cyc = cyc;
         end
         if (out_valid) begin
            n_ov++;
            if (first_ov_cyc < 0) first_ov_cyc = cyc;
            if (held && (out_data !== held_d)) stall_bad++;
            if (out_ready) begin
               got.push_back(out_data.key);
               if (out_last) begin n_last++; last_pos = got.size() - 1; end
               held = 0;
            end else begin
               n_stall++; held = 1; held_d = out_data;
            end
         end
         if (done) begin
            n_done++; done_pos = got.size() - 1;
         end
         @(posedge clk); #1;
         cyc++;
         if (n_done != 0) begin timeout = 0; break; end
      end
      in_valid = 0; in_last = 0; out_ready = 0; in_data = '0;
   endtask

   task automatic check_keys(input string name, input logic [15:0] exp[$]);
      n_vec++;
      if (got.size() != exp.size()) begin
         n_err++;
         $display("FAIL %s_len: got %0d outputs, expected %0d", name, got.size(), exp.size());
      end else begin
         for (int i = 0; i < exp.size(); i++) begin
            n_vec++;
            if (got[i] !== exp[i]) begin
               n_err++;
               $display("FAIL %s[%0d]: got key %0d expected %0d", name, i, got[i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1; in_valid = 1; in_data = mk(16'd3); in_last = 0; out_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      n_vec++; if (count !== '0)      begin n_err++; $display("FAIL rst_count: got %0d expected 0", count); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
      n_vec++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL rst_in_ready: got %0b expected 0", in_ready); end
      n_vec++; if (pq_ivalid !== 1'b0) begin n_err++; $display("FAIL rst_pq_ivalid: got %0b expected 0", pq_ivalid); end
      n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL rst_done: got %0b expected 0", done); end
      n_vec++; if ({err_drop, err_ovf} !== 2'b00) begin n_err++; $display("FAIL rst_errs: got %b expected 00", {err_drop, err_ovf}); end
      @(posedge clk); #1;
      rst = 0; in_valid = 0; out_ready = 0;
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready: got %0b expected 1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      in_q = '{mk(16'd7), mk(16'd3), mk(16'd9), mk(16'd1)};
      rdy_pat = '{};
      drive_frame();
      n_vec++; if (timeout) begin n_err++; $display("FAIL basic_timeout: got no done, expected done"); end
      check_keys("basic", '{16'd1, 16'd3, 16'd7, 16'd9});
      n_vec++; if (n_last != 1 || last_pos != 3) begin n_err++; $display("FAIL basic_last: got %0d at %0d expected 1 at 3", n_last, last_pos); end
      n_vec++; if (n_done != 1 || done_pos != 3) begin n_err++; $display("FAIL basic_done: got %0d at %0d expected 1 at 3", n_done, done_pos); end
      n_vec++; if (count !== '0) begin n_err++; $display("FAIL basic_count_end: got %0d expected 0", count); end
      n_vec++; if (peak != 4) begin n_err++; $display("FAIL basic_peak: got %0d expected 4", peak); end
      n_vec++; if (first_ov_cyc <= last_acc_cyc) begin n_err++; $display("FAIL basic_latency: got first out cyc %0d expected > %0d", first_ov_cyc, last_acc_cyc); end
      n_vec++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL basic_ovf: got %0b expected 0", err_ovf); end
   endtask

   task automatic test_stall();
      in_q = '{mk(16'd7), mk(16'd3), mk(16'd9), mk(16'd1)};
      rdy_pat = '{1, 0, 0, 1};
      drive_frame();
      n_vec++; if (timeout) begin n_err++; $display("FAIL stall_timeout: got no done, expected done"); end
      check_keys("stall", '{16'd1, 16'd3, 16'd7, 16'd9});
      n_vec++; if (n_stall == 0) begin n_err++; $display("FAIL stall_seen: got %0d stalls expected >0", n_stall); end
      n_vec++; if (stall_bad != 0) begin n_err++; $display("FAIL stall_stable: got %0d changes expected 0", stall_bad); end
      rdy_pat = '{};
   endtask

   task automatic test_drop();
      in_q = '{mk(16'd5), mk(KEYINF), mk(16'd2)};
      drive_frame();
      n_vec++; if (timeout) begin n_err++; $display("FAIL drop_timeout: got no done, expected done"); end
      check_keys("drop", '{16'd2, 16'd5});
      n_vec++; if (err_drop !== 1'b1) begin n_err++; $display("FAIL drop_err: got %0b expected 1", err_drop); end
      n_vec++; if (peak != 2) begin n_err++; $display("FAIL drop_peak: got %0d expected 2", peak); end
      n_vec++; if (n_acc != 3) begin n_err++; $display("FAIL drop_acc: got %0d expected 3", n_acc); end
   endtask

   task automatic test_empty();
      in_q = '{mk(KEYINF)};
      drive_frame();
      n_vec++; if (n_done != 1) begin n_err++; $display("FAIL empty_done: got %0d expected 1", n_done); end
      n_vec++; if (n_ov != 0) begin n_err++; $display("FAIL empty_out_valid: got %0d cycles expected 0", n_ov); end
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b1 || count !== '0) begin n_err++; $display("FAIL empty_idle: got rdy %0b cnt %0d expected 1 0", in_ready, count); end
      @(posedge clk); #1;
   endtask

   task automatic test_overflow();
      in_q = '{mk(16'd8), mk(16'd6), mk(16'd4), mk(16'd2), mk(16'd1), mk(16'd0)};
      drive_frame();
      n_vec++; if (timeout) begin n_err++; $display("FAIL ovf_timeout: got no done, expected done"); end
      check_keys("ovf", '{16'd2, 16'd4, 16'd6, 16'd8});
      n_vec++; if (err_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_err: got %0b expected 1", err_ovf); end
      n_vec++; if (n_acc != 6) begin n_err++; $display("FAIL ovf_acc: got %0d expected 6", n_acc); end
      n_vec++; if (last_pos != 3) begin n_err++; $display("FAIL ovf_last: got %0d expected 3", last_pos); end
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ovf_idle_rdy: got %0b expected 1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_rst_drain();
      kv_t f[4];
      f[0] = mk(16'd6); f[1] = mk(16'd5); f[2] = mk(16'd4); f[3] = mk(16'd3);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1; in_data = f[i]; in_last = (i == 3); out_ready = 0;
         @(posedge clk); #1;
      end
      in_valid = 0; in_last = 0; out_ready = 1;
      @(negedge clk);
      n_vec++; if (!(out_valid && out_data.key == 16'd3)) begin n_err++; $display("FAIL rd_pop0: got v%0b key %0d expected v1 key 3", out_valid, out_data.key); end
      @(posedge clk); #1;
      @(negedge clk);
      n_vec++; if (!(out_valid && out_data.key == 16'd4)) begin n_err++; $display("FAIL rd_pop1: got v%0b key %0d expected v1 key 4", out_valid, out_data.key); end
      @(posedge clk); #1;
      out_ready = 0; rst = 1;
      @(negedge clk);
      n_vec++; if (count !== CNT_W'(2)) begin n_err++; $display("FAIL rd_left: got %0d expected 2", count); end
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      n_vec++; if (count !== '0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rd_after: got cnt %0d v%0b expected 0 0", count, out_valid); end
      n_vec++; if ({err_drop, err_ovf} !== 2'b00) begin n_err++; $display("FAIL rd_errs: got %b expected 00", {err_drop, err_ovf}); end
      @(posedge clk); #1;
      in_q = '{mk(16'd4), mk(16'd2)};
      drive_frame();
      check_keys("rd_new", '{16'd2, 16'd4});
      n_vec++; if (n_done != 1) begin n_err++; $display("FAIL rd_new_done: got %0d expected 1", n_done); end
   endtask

   initial begin
      rst = 1; in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
      test_reset();
      test_basic();
      test_stall();
      test_drop();
      test_empty();
      test_overflow();
      test_rst_drain();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
